// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, default error read data
// and the write-strobe width. Imported by bus_arbiter and later bus blocks.
package bus_pkg;

  localparam int          WSTRB_W      = 4;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection, purely combinational.
//   valid0/valid1 : requests
//   last          : master that won most recently (0 or 1)
//   any           : at least one request present
//   winner        : index of the master to grant (meaningful when any=1)
module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic any,
  output logic winner
);

  assign any    = valid0 | valid1;
  // On a tie the master that did not win last time goes next.
  assign winner = (valid0 & valid1) ? ~last : valid1;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one valid/ready memory port.
//   clk, rst_n          : clock, async active-low reset
//   m0_* / m1_*         : master requests (valid, addr, wdata, wstrb) and
//                         responses (ready pulse, rdata)
//   s_*                 : slave request (valid, addr, wdata, wstrb) and
//                         completion (ready, rdata)
//   timeout             : one-cycle pulse the cycle after a watchdog expiry
// A grant is held until s_ready, the master withdraws, or the watchdog
// terminates it with ERR_DATA. Every grant is followed by one IDLE cycle.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_valid,
  input  logic [31:0]        m0_addr,
  input  logic [31:0]        m0_wdata,
  input  logic [WSTRB_W-1:0] m0_wstrb,
  output logic               m0_ready,
  output logic [31:0]        m0_rdata,
  input  logic               m1_valid,
  input  logic [31:0]        m1_addr,
  input  logic [31:0]        m1_wdata,
  input  logic [WSTRB_W-1:0] m1_wstrb,
  output logic               m1_ready,
  output logic [31:0]        m1_rdata,
  output logic               s_valid,
  output logic [31:0]        s_addr,
  output logic [31:0]        s_wdata,
  output logic [WSTRB_W-1:0] s_wstrb,
  input  logic               s_ready,
  input  logic [31:0]        s_rdata,
  output logic               timeout
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  arb_state_e  state, state_nx;
  logic        last, last_nx;
  logic [15:0] wd, wd_nx;

  logic pick_any, pick_win;
  logic granted, gsel, g_valid, at_limit, expire, done;

  rr_pick2 u_pick (
    .valid0 (m0_valid),
    .valid1 (m1_valid),
    .last   (last),
    .any    (pick_any),
    .winner (pick_win)
  );

  assign granted  = (state != IDLE);
  assign gsel     = (state == GRANT1);
  assign g_valid  = gsel ? m1_valid : m0_valid;
  assign at_limit = granted && (wd == WD_LAST);
  // A withdrawn request is an abort, not an expiry; s_ready always wins.
  assign expire   = at_limit && !s_ready && g_valid;
  assign done     = s_ready || expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      wd      <= wd_nx;
      timeout <= expire;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    wd_nx    = '0;
    unique case (state)
      IDLE: begin
        if (pick_any) state_nx = pick_win ? GRANT1 : GRANT0;
      end
      GRANT0, GRANT1: begin
        if (done) begin
          state_nx = IDLE;
          last_nx  = gsel;
        end else if (!g_valid) begin
          state_nx = IDLE;
        end else begin
          wd_nx = wd + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // s_valid drops in the final watchdog cycle without looking at s_ready,
  // which keeps s_ready -> s_valid free of a combinational path. A slave
  // that still answers in that cycle completes the transfer normally.
  assign s_valid = granted && !at_limit;

  always_comb begin
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (state == GRANT0) begin
      s_addr   = m0_addr;
      s_wdata  = m0_wdata;
      s_wstrb  = m0_wstrb;
      m0_ready = done;
      m0_rdata = expire ? ERR_DATA : s_rdata;
    end else if (state == GRANT1) begin
      s_addr   = m1_addr;
      s_wdata  = m1_wdata;
      s_wstrb  = m1_wstrb;
      m1_ready = done;
      m1_rdata = expire ? ERR_DATA : s_rdata;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (TIMEOUT=8). Stimulus pushes expected
// {port, rdata, cycle, timeout} entries; the monitor pops one per ready.
module tb_bus_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        timeout;

  bus_arbiter #(.TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout(timeout)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: 0 zero-wait, 1 registered (ready one cycle later),
  // 2 never ready, 3 ready tied high.
  int          mode = 0;
  logic [31:0] slv_rdata = '0;
  logic        s_valid_d;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) s_valid_d <= 1'b0;
    else        s_valid_d <= s_valid && !s_ready;
  always_comb begin
    s_ready = 1'b0;
    case (mode)
      0: s_ready = s_valid;
      1: s_ready = s_valid && s_valid_d;
      3: s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end
  assign s_rdata = slv_rdata;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
    bit          tmo;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int checks = 0;
  int passes = 0;
  int tmo_exp = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: one scoreboard entry per ready pulse, then timeout pulse check.
  always @(negedge clk) begin
    if (m0_ready || m1_ready) begin
      if (m0_ready && m1_ready) chk("dual_ready", 32'd1, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_ready", {31'b0, m1_ready}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sbq.pop_front();
        chk("ready_port",  {31'b0, m1_ready}, 32'(mon_e.port));
        chk("ready_rdata", m1_ready ? m1_rdata : m0_rdata, mon_e.data);
        chk("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.tmo) tmo_exp = cyc + 1;
      end
    end
    if (cyc == tmo_exp)  chk("timeout_pulse", {31'b0, timeout}, 32'd1);
    else if (timeout)    chk("spurious_timeout", {31'b0, timeout}, 32'd0);
  end

  task automatic drive(input int port, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st);
    if (port == 0) begin
      m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = st;
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = st;
    end
  endtask

  // Hold until own ready (bounded), then withdraw after that edge.
  task automatic wait_done(input int port);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port == 1 ? m1_ready : m0_ready) && n < 60);
    if (n >= 60) chk("ready_wait_expired", 32'(port), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    if (port == 0) begin
      m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    end else begin
      m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    end
  endtask

  task automatic xact(input int port, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st);
    drive(port, a, d, st);
    wait_done(port);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  int n0;

  initial begin
    rst_n = 1'b0;
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_s_valid",  {31'b0, s_valid},  32'd0);
    chk("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
    chk("rst_timeout",  {31'b0, timeout},  32'd0);
    chk("rst_s_wstrb",  {28'b0, s_wstrb},  32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single m0 read, registered slave: ready at N+2.
    mode = 1; slv_rdata = 32'h1234_5678;
    sbq.push_back('{0, 32'h1234_5678, cyc + 2, 1'b0});
    xact(0, 32'h0000_0100, 32'h0, 4'h0);
    next_cycle();

    // Both valid right after reset, zero-wait: m0,m1,m0,m1 two cycles apart.
    rst_n = 1'b0; next_cycle(); rst_n = 1'b1; next_cycle();
    mode = 0; slv_rdata = 32'h5555_AAAA;
    n0 = cyc;
    sbq.push_back('{0, 32'h5555_AAAA, n0 + 1, 1'b0});
    sbq.push_back('{1, 32'h5555_AAAA, n0 + 3, 1'b0});
    sbq.push_back('{0, 32'h5555_AAAA, n0 + 5, 1'b0});
    sbq.push_back('{1, 32'h5555_AAAA, n0 + 7, 1'b0});
    fork
      begin xact(0, 32'h0000_0010, 32'h0, 4'h0); xact(0, 32'h0000_0014, 32'h0, 4'h0); end
      begin xact(1, 32'h0000_0020, 32'h0, 4'h0); xact(1, 32'h0000_0024, 32'h0, 4'h0); end
    join
    next_cycle();

    // m1 write: s_* mirror m1 while granted, zero in IDLE.
    mode = 1; slv_rdata = 32'h0BAD_F00D;
    sbq.push_back('{1, 32'h0BAD_F00D, cyc + 2, 1'b0});
    drive(1, 32'h1000_0004, 32'hAABB_CCDD, 4'b0011);
    @(negedge clk);
    chk("idle_s_valid", {31'b0, s_valid}, 32'd0);
    chk("idle_s_wstrb", {28'b0, s_wstrb}, 32'd0);
    @(negedge clk);
    chk("g1_s_valid", {31'b0, s_valid}, 32'd1);
    chk("g1_s_addr",  s_addr,  32'h1000_0004);
    chk("g1_s_wdata", s_wdata, 32'hAABB_CCDD);
    chk("g1_s_wstrb", {28'b0, s_wstrb}, 32'h3);
    wait_done(1);
    @(negedge clk);
    chk("post_s_valid", {31'b0, s_valid}, 32'd0);
    chk("post_s_wstrb", {28'b0, s_wstrb}, 32'd0);
    chk("post_s_addr",  s_addr, 32'd0);
    next_cycle();

    // Watchdog: slave never ready, ready at N+8 with error data.
    mode = 2;
    sbq.push_back('{0, 32'hDEAD_BEEF, cyc + TMO, 1'b1});
    xact(0, 32'h0000_0200, 32'h0, 4'h0);
    @(negedge clk);
    chk("tmo_idle_s_valid", {31'b0, s_valid}, 32'd0);
    next_cycle();

    // Abort: m0 withdraws mid-grant, pending m1 is granted after one IDLE.
    mode = 2;
    drive(0, 32'h0000_0300, 32'h0, 4'h0);
    next_cycle();
    drive(1, 32'h0000_0400, 32'h0, 4'h0);
    @(negedge clk);
    chk("ab_g0_addr", s_addr, 32'h0000_0300);
    next_cycle();
    m0_valid = 1'b0; m0_addr = '0;
    next_cycle();
    mode = 1; slv_rdata = 32'h7777_0001;
    sbq.push_back('{1, 32'h7777_0001, cyc + 2, 1'b0});
    @(negedge clk);
    chk("ab_idle_s_valid", {31'b0, s_valid}, 32'd0);
    @(negedge clk);
    chk("ab_g1_s_valid", {31'b0, s_valid}, 32'd1);
    chk("ab_g1_addr", s_addr, 32'h0000_0400);
    wait_done(1);
    next_cycle();

    // Reset mid-GRANT1 with the slave trying to respond.
    mode = 2;
    drive(1, 32'h0000_0500, 32'h0, 4'h0);
    next_cycle();
    @(negedge clk);
    chk("pre_rst_s_valid", {31'b0, s_valid}, 32'd1);
    next_cycle();
    rst_n = 1'b0; mode = 3;
    #1;
    chk("midrst_s_valid",  {31'b0, s_valid},  32'd0);
    chk("midrst_m1_ready", {31'b0, m1_ready}, 32'd0);
    chk("midrst_s_addr",   s_addr, 32'd0);
    m1_valid = 1'b0; m1_addr = '0;
    next_cycle();
    rst_n = 1'b1; mode = 0; slv_rdata = 32'h0000_CAFE;
    next_cycle();
    n0 = cyc;
    sbq.push_back('{0, 32'h0000_CAFE, n0 + 1, 1'b0});
    sbq.push_back('{1, 32'h0000_CAFE, n0 + 3, 1'b0});
    fork
      xact(0, 32'h0000_0600, 32'h0, 4'h0);
      xact(1, 32'h0000_0700, 32'h0, 4'h0);
    join

    repeat (4) next_cycle();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter sharing one native valid/ready memory port (work RAM or char RAM) between the CPU and a second requester (loader/DMA). Round-robin grant, grant held until the slave completes, and a watchdog that terminates transactions the slave never acknowledges. It sits between the masters and the slave's chip-select/ready logic in `top`.

## Interface
- `TIMEOUT`, 255: cycles a granted transaction may wait for `s_ready` before forced termination (1..65535).
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on timeout.
- `clk` input 1: system clock (25 MHz).
- `rst_n` input 1: asynchronous, active-low reset.
- `m0_valid`, `m1_valid` input 1: master request (m0 = CPU, m1 = DMA).
- `m0_addr`, `m1_addr` input 32: byte address.
- `m0_wdata`, `m1_wdata` input 32: write data.
- `m0_wstrb`, `m1_wstrb` input 4: byte write enables; 0 = read.
- `m0_ready`, `m1_ready` output 1: transaction complete, one cycle.
- `m0_rdata`, `m1_rdata` output 32: read data, valid while own `ready` high.
- `s_valid` output 1: request to slave.
- `s_addr` output 32, `s_wdata` output 32, `s_wstrb` output 4: muxed from granted master.
- `s_ready` input 1, `s_rdata` input 32: slave completion and data.
- `timeout` output 1: one-cycle pulse when watchdog fires.

## Operation
- States: IDLE, GRANT0, GRANT1. Registered state, last-winner bit `last`, watchdog counter `wd` (16-bit).
- IDLE: one requester valid → grant it. Both valid → grant the master not equal to `last` (round-robin). None → stay.
- GRANTx: `s_valid`=1; `s_addr/wdata/wstrb` = master x fields; other master sees `ready`=0.
- `mx_ready` = `s_ready` in GRANTx (combinational); `mx_rdata` = `s_rdata` when granted, else 0.
- Completion (`s_ready` in GRANTx): next state IDLE, `last`←x, `wd`←0.
- Abort: master x drops `valid` while GRANTx without `s_ready` → IDLE, `last` unchanged, no `ready` issued.
- Watchdog: `wd` increments each GRANT cycle without `s_ready`; at `wd`==TIMEOUT−1 the arbiter asserts `mx_ready` with `mx_rdata`=ERR_DATA, `s_valid`=0 that cycle, `timeout` pulses, next state IDLE, `last`←x.
- `s_ready` and watchdog expiry in same cycle: `s_ready` wins, no `timeout`.
- IDLE outputs: `s_valid`=0, `s_wstrb`=0, `s_addr`/`s_wdata`=0, all `ready`=0.
- Reset (any time, incl. mid-transaction): state IDLE, `last`=1 (m0 wins first tie), `wd`=0, `timeout`=0; all outputs 0 immediately.

## Timing
- Request in IDLE at cycle N → `s_valid` from cycle N+1 (one arbitration cycle).
- Zero-wait slave: `ready` at earliest N+1; registered slave (RAM/ROM): N+2.
- Mandatory one IDLE cycle between back-to-back grants; continuous two-master load alternates m0,m1,m0,…
- Timeout `ready` at cycle N+TIMEOUT.
- `timeout` registered: high in the cycle after the expiry `ready`.

## Structure
- Package `bus_pkg`: state enum (IDLE/GRANT0/GRANT1), default ERR_DATA constant, wstrb width constant — shared with future bus blocks.
- Sub-module `rr_pick2`: pure round-robin next-winner from {valid0, valid1, last}; reused by later N-way arbiters. Everything else in `bus_arbiter`.

## Test plan
- Single m0 read, slave ready 1 cycle after `s_valid`, rdata 32'h1234_5678 → m0_ready at N+2 with that data; m1_ready stays 0.
- Both valid from reset, continuous, slave zero-wait → grant order m0,m1,m0,m1; each `ready` separated by 2 cycles.
- m1 write addr 32'h1000_0004, wstrb 4'b0011, wdata 32'hAABB_CCDD → s_* mirror exactly while GRANT1; `s_wstrb`=0 in IDLE.
- Slave never ready, TIMEOUT=8 → m0_ready at N+8 with 32'hDEAD_BEEF, `timeout` pulse at N+9, state IDLE.
- m0 drops valid in GRANT0 before `s_ready` → `s_valid` low next cycle, no m0_ready, pending m1 granted next (last unchanged → m1 wins as sole requester).
- Assert `rst_n`=0 mid-GRANT1 → `s_valid`, `m1_ready` 0 within same cycle; after release both valid → m0 granted first.
